// File: rtl/seizure_pkg.sv
// Shared types and defaults for the seizure alarm voter.
//   alarm_state_t : voter FSM states
//   HIST_LEN_DEF  : default verdict history depth (windows)
//   HOLDOFF_DEF   : default number of windows ignored after an ack
//   CNT_W_DEF     : default window counter width
//   VOTE_W        : width of vote counts and cfg_k
package seizure_pkg;

   typedef enum logic [1:0] {
      ARMED   = 2'd0,
      ALARM   = 2'd1,
      HOLDOFF = 2'd2
   } alarm_state_t;

   localparam int unsigned HIST_LEN_DEF = 8;
   localparam int unsigned HOLDOFF_DEF  = 4;
   localparam int unsigned CNT_W_DEF    = 16;
   localparam int unsigned VOTE_W       = 4;

endpackage

// File: rtl/seizure_alarm_voter_if.sv
// Bus between the DCTC/host side (master) and the alarm voter (slave).
//   dctc_finish, seizure_prediction : window framing level and verdict from DCTC
//   alarm_ack, cfg_k                : host acknowledge pulse and vote threshold
//   alarm, alarm_irq                : latched alarm level and assertion pulse
//   vote_count, window_count        : live history vote and closed-window count
//   alarm_window_idx                : window_count at alarm rise (ALARM_TIMESTAMP_EN only)
interface seizure_alarm_voter_if
   import seizure_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
);

   logic              dctc_finish;
   logic              seizure_prediction;
   logic              alarm_ack;
   logic [VOTE_W-1:0] cfg_k;
   logic              alarm;
   logic              alarm_irq;
   logic [VOTE_W-1:0] vote_count;
   logic [CNT_W-1:0]  window_count;
`ifdef ALARM_TIMESTAMP_EN
   logic [CNT_W-1:0]  alarm_window_idx;

   modport master (
      output dctc_finish, seizure_prediction, alarm_ack, cfg_k,
      input  alarm, alarm_irq, vote_count, window_count, alarm_window_idx
   );
   modport slave (
      input  dctc_finish, seizure_prediction, alarm_ack, cfg_k,
      output alarm, alarm_irq, vote_count, window_count, alarm_window_idx
   );
`else
   modport master (
      output dctc_finish, seizure_prediction, alarm_ack, cfg_k,
      input  alarm, alarm_irq, vote_count, window_count
   );
   modport slave (
      input  dctc_finish, seizure_prediction, alarm_ack, cfg_k,
      output alarm, alarm_irq, vote_count, window_count
   );
`endif

endinterface

// File: rtl/vote_popcount.sv
// Combinational population count of the verdict history.
//   hist_i  : HIST_LEN-bit verdict history
//   count_c : number of set bits (combinational)
module vote_popcount
   import seizure_pkg::*;
#(
   parameter int unsigned HIST_LEN = HIST_LEN_DEF
) (
   input  logic [HIST_LEN-1:0] hist_i,
   output logic [VOTE_W-1:0]   count_c
);

   always_comb begin
      count_c = '0;
      for (int unsigned i = 0; i < HIST_LEN; i++) begin
         count_c = count_c + VOTE_W'(hist_i[i]);
      end
   end

endmodule

// File: rtl/seizure_alarm_voter.sv
// K-of-N seizure alarm voter: records one verdict per DCTC window, raises a latched
// alarm when cfg_k of the last HIST_LEN verdicts are positive, holds it until the host
// acks, then ignores HOLDOFF_WIN closed windows before re-arming.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : dctc_finish, seizure_prediction, alarm_ack, cfg_k in;
//                  alarm, alarm_irq, vote_count, window_count out
// Optional build macro ALARM_TIMESTAMP_EN adds bus.alarm_window_idx, the window_count
// captured when alarm rises.
module seizure_alarm_voter
   import seizure_pkg::*;
#(
   parameter int unsigned HIST_LEN    = HIST_LEN_DEF,
   parameter int unsigned HOLDOFF_WIN = HOLDOFF_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   seizure_alarm_voter_if.slave bus
);

   localparam int unsigned HOLD_W = $clog2(HOLDOFF_WIN + 1);

   alarm_state_t      state_q, state_d;
   logic              fin_d_q, fin_dd_q;
   logic [1:0]        fin_vld_q;
   logic              pred_seen_q, pred_seen_d;
   logic [HIST_LEN-1:0] hist_q, hist_d;
   logic [VOTE_W-1:0] vote_q, vote_d;
   logic [CNT_W-1:0]  win_q, win_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              alarm_q, alarm_d;
   logic              irq_q, irq_d;
   logic              ack_take;

   logic              close_c;
   logic              verdict_c;
   logic [VOTE_W-1:0] k_eff_c;
   logic              fire_c;

   // Finish edge detector; fin_vld_q keeps the reset value of fin_dd_q from faking an edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fin_d_q   <= 1'b0;
         fin_dd_q  <= 1'b0;
         fin_vld_q <= 2'b00;
      end else begin
         fin_d_q   <= bus.dctc_finish;
         fin_dd_q  <= fin_d_q;
         fin_vld_q <= {fin_vld_q[0], 1'b1};
      end
   end

   // Window closes one cycle after the finish rising edge to absorb verdict skew.
   assign close_c   = fin_vld_q[1] & fin_d_q & ~fin_dd_q;
   assign verdict_c = pred_seen_q | bus.seizure_prediction;
   assign k_eff_c   = (bus.cfg_k == '0) ? VOTE_W'(1) : bus.cfg_k;
   assign fire_c    = (state_q == ARMED) && (vote_q >= k_eff_c);

   vote_popcount #(.HIST_LEN(HIST_LEN)) u_popcount (
      .hist_i  (hist_d),
      .count_c (vote_d)
   );

   // Next-state: window bookkeeping, then FSM, then ack override of the history.
   always_comb begin
      state_d     = state_q;
      hist_d      = hist_q;
      win_d       = win_q;
      hold_d      = hold_q;
      alarm_d     = alarm_q;
      irq_d       = 1'b0;
      ack_take    = 1'b0;
      pred_seen_d = pred_seen_q | bus.seizure_prediction;

      if (close_c) begin
         pred_seen_d = 1'b0;
         hist_d      = {hist_q[HIST_LEN-2:0], verdict_c};
         if (win_q != '1) begin
            win_d = win_q + CNT_W'(1);
         end
      end

      unique case (state_q)
         ARMED: begin
            if (fire_c) begin
               state_d = ALARM;
               alarm_d = 1'b1;
               irq_d   = 1'b1;
            end
         end
         ALARM: begin
            if (bus.alarm_ack) begin
               state_d  = HOLDOFF;
               alarm_d  = 1'b0;
               hold_d   = HOLD_W'(HOLDOFF_WIN);
               ack_take = 1'b1;
            end
         end
         HOLDOFF: begin
            // The close seen with the counter at zero re-arms; its vote is judged next cycle.
            if (close_c) begin
               if (hold_q == '0) begin
                  state_d = ARMED;
               end else begin
                  hold_d = hold_q - HOLD_W'(1);
               end
            end
         end
         default: state_d = ARMED;
      endcase

      // Ack wipes the history; a verdict closing in the same cycle survives as the sole entry.
      if (ack_take) begin
         hist_d = close_c ? HIST_LEN'(verdict_c) : '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ARMED;
         pred_seen_q <= 1'b0;
         hist_q      <= '0;
         vote_q      <= '0;
         win_q       <= '0;
         hold_q      <= '0;
         alarm_q     <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pred_seen_q <= pred_seen_d;
         hist_q      <= hist_d;
         vote_q      <= vote_d;
         win_q       <= win_d;
         hold_q      <= hold_d;
         alarm_q     <= alarm_d;
         irq_q       <= irq_d;
      end
   end

   assign bus.alarm        = alarm_q;
   assign bus.alarm_irq    = irq_q;
   assign bus.vote_count   = vote_q;
   assign bus.window_count = win_q;

`ifdef ALARM_TIMESTAMP_EN
   logic [CNT_W-1:0] ts_q, ts_d;

   // Capture the window index on the same edge that raises alarm.
   always_comb begin
      ts_d = ts_q;
      if (fire_c) begin
         ts_d = win_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_d;
      end
   end

   assign bus.alarm_window_idx = ts_q;
`endif

endmodule

// File: tb/tb_seizure_alarm_voter.sv
// Bench for seizure_alarm_voter: directed table, hand sequences and random windows,
// all checked against a window-level reference model of the voting rules.
module tb_seizure_alarm_voter;
   import seizure_pkg::*;

   localparam int unsigned HL  = 8;
   localparam int unsigned HW  = 4;
   localparam int unsigned CW  = 16;
   localparam int unsigned CWS = 4;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   int   total   = 0;
   int   bad     = 0;

   // Reference model state
   bit          m_hist[$];
   bit          m_alarm;
   int          m_ign;
   int unsigned m_wc;
   int unsigned m_idx;
   int unsigned k_cur;

   typedef struct {
      bit          ack_before;
      bit          mid;
      bit          at_close;
      bit          ack_close;
      int unsigned vote;
      bit          alarm;
      bit          irq;
   } vec_t;
   vec_t tv[13];

   always #5 clk = ~clk;

   seizure_alarm_voter_if #(.CNT_W(CW))  bus ();
   seizure_alarm_voter_if #(.CNT_W(CWS)) sbus ();

   seizure_alarm_voter #(.HIST_LEN(HL), .HOLDOFF_WIN(HW), .CNT_W(CW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Narrow-counter copy sharing the framing, used to reach counter saturation quickly.
   seizure_alarm_voter #(.HIST_LEN(HL), .HOLDOFF_WIN(HW), .CNT_W(CWS)) dut_sat (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (sbus)
   );

   assign sbus.dctc_finish        = bus.dctc_finish;
   assign sbus.seizure_prediction = bus.seizure_prediction;
   assign sbus.alarm_ack          = 1'b0;
   assign sbus.cfg_k              = 4'd0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int unsigned m_votes();
      int unsigned n = 0;
      foreach (m_hist[i]) if (m_hist[i]) n++;
      return n;
   endfunction

   task automatic model_reset(input int unsigned k);
      m_hist.delete();
      m_alarm = 1'b0;
      m_ign   = 0;
      m_wc    = 0;
      m_idx   = 0;
      k_cur   = k;
   endtask

   task automatic cyc(input logic fin, input logic pred, input logic ack);
      bus.dctc_finish        = fin;
      bus.seizure_prediction = pred;
      bus.alarm_ack          = ack;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input logic [3:0] k);
      bus.dctc_finish        = 1'b0;
      bus.seizure_prediction = 1'b0;
      bus.alarm_ack          = 1'b0;
      bus.cfg_k              = k;
      reset_n                = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      model_reset(32'(k));
   endtask

   // Standalone ack: only an active alarm reacts, clearing alarm and history at once.
   task automatic do_ack();
      if (m_alarm) begin
         m_hist.delete();
         m_alarm = 1'b0;
         m_ign   = HW + 1;
      end
      cyc(1'b0, 1'b0, 1'b1);
      check("ack_alarm", 32'(bus.alarm), 32'(m_alarm));
      check("ack_vote", 32'(bus.vote_count), m_votes());
      check("ack_irq", 32'(bus.alarm_irq), 32'd0);
   endtask

   // One analysis window: optional mid-window pulse, rising finish, close cycle with
   // optional pulse/ack, then one cycle for the alarm decision to appear.
   task automatic window(input bit mid, input bit cl, input bit ac,
                         output logic [3:0] vote, output logic [CW-1:0] wc,
                         output logic alarm_f, output logic irq_f);
      logic          irq_other;
      logic [CWS-1:0] swc;
      bit            v, was_ack, exp_irq;
      int unsigned   keff;
      irq_other = 1'b0;
      cyc(1'b0, mid, 1'b0);  irq_other |= bus.alarm_irq;
      cyc(1'b0, 1'b0, 1'b0); irq_other |= bus.alarm_irq;
      cyc(1'b1, 1'b0, 1'b0); irq_other |= bus.alarm_irq;
      cyc(1'b1, cl, ac);     irq_other |= bus.alarm_irq;
      vote = bus.vote_count;
      wc   = bus.window_count;
      swc  = sbus.window_count;
      cyc(1'b0, 1'b0, 1'b0);
      alarm_f = bus.alarm;
      irq_f   = bus.alarm_irq;

      v       = mid | cl;
      was_ack = ac && m_alarm;
      if (was_ack) begin
         m_hist.delete();
         m_alarm = 1'b0;
         m_ign   = HW + 1;
      end
      m_hist.push_back(v);
      if (m_hist.size() > HL) void'(m_hist.pop_front());
      if (!was_ack && m_ign > 0) m_ign--;
      if (m_wc < 32'hFFFF) m_wc++;
      keff    = (k_cur == 0) ? 1 : k_cur;
      exp_irq = !m_alarm && (m_ign == 0) && (m_votes() >= keff);
      if (exp_irq) begin
         m_alarm = 1'b1;
         m_idx   = m_wc;
      end

      check("win_vote", 32'(vote), m_votes());
      check("win_count", 32'(wc), m_wc);
      check("sat_count", 32'(swc), (m_wc > 15) ? 32'd15 : m_wc);
      check("win_alarm", 32'(alarm_f), 32'(m_alarm));
      check("win_irq", 32'(irq_f), 32'(exp_irq));
      check("irq_early", 32'(irq_other), 32'd0);
`ifdef ALARM_TIMESTAMP_EN
      check("win_idx", 32'(bus.alarm_window_idx), m_idx);
`endif
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]    vote;
      logic [CW-1:0] wc;
      logic          al, irq;

      // K-of-N with sticky/close-cycle verdicts, no re-irq in ALARM, ack, holdoff, ack+close.
      tv[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 1'b0, 1'b0};
      tv[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 1'b0, 1'b0};
      tv[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd2, 1'b0, 1'b0};
      tv[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0};
      tv[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 1'b1, 1'b1};
      tv[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd4, 1'b1, 1'b0};
      tv[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 1'b0, 1'b0};
      tv[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0};
      tv[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd3, 1'b0, 1'b0};
      tv[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd4, 1'b0, 1'b0};
      tv[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd5, 1'b1, 1'b1};
      tv[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0};
      tv[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 1'b0, 1'b0};

      do_reset(4'd3);
      check("rst_alarm", 32'(bus.alarm), 32'd0);
      check("rst_vote", 32'(bus.vote_count), 32'd0);
      check("rst_wc", 32'(bus.window_count), 32'd0);

      for (int i = 0; i < 13; i++) begin
         if (tv[i].ack_before) begin
            do_ack();
            check("tv_ack_alarm", 32'(bus.alarm), 32'd0);
            check("tv_ack_vote", 32'(bus.vote_count), 32'd0);
         end
         window(tv[i].mid, tv[i].at_close, tv[i].ack_close, vote, wc, al, irq);
         check("tv_vote", 32'(vote), tv[i].vote);
         check("tv_wc", 32'(wc), 32'(i + 1));
         check("tv_alarm", 32'(al), 32'(tv[i].alarm));
         check("tv_irq", 32'(irq), 32'(tv[i].irq));
      end

      // cfg_k=1, all positive: ack, four ignored closes, irq on the fifth.
      do_reset(4'd1);
      window(1'b1, 1'b1, 1'b0, vote, wc, al, irq);
      check("t4_first_irq", 32'(irq), 32'd1);
      do_ack();
      check("t4_ack_alarm", 32'(bus.alarm), 32'd0);
      check("t4_ack_vote", 32'(bus.vote_count), 32'd0);
      for (int i = 1; i <= 5; i++) begin
         window(1'b1, 1'b1, 1'b0, vote, wc, al, irq);
         check("t4_hold_irq", 32'(irq), (i == 5) ? 32'd1 : 32'd0);
      end

      // Asynchronous reset in the middle of ALARM.
      check("pre_rst_alarm", 32'(bus.alarm), 32'd1);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("arst_alarm", 32'(bus.alarm), 32'd0);
      check("arst_irq", 32'(bus.alarm_irq), 32'd0);
      check("arst_vote", 32'(bus.vote_count), 32'd0);
      check("arst_wc", 32'(bus.window_count), 32'd0);
      check("arst_state", 32'(dut.state_q), 32'(ARMED));
      do_reset(4'd0);

      // cfg_k=0 acts as 1: an empty vote must not alarm, one positive must.
      window(1'b0, 1'b0, 1'b0, vote, wc, al, irq);
      check("k0_no_alarm", 32'(al), 32'd0);
      window(1'b1, 1'b0, 1'b0, vote, wc, al, irq);
      check("k0_irq", 32'(irq), 32'd1);

      // cfg_k above the history depth never alarms.
      do_reset(4'd9);
      for (int i = 0; i < 20; i++) begin
         window(1'b1, 1'b0, 1'b0, vote, wc, al, irq);
         check("k9_alarm", 32'(al), 32'd0);
      end
      check("k9_vote", 32'(vote), 32'd8);
      check("sat_full", 32'(sbus.window_count), 32'hF);

      // Alarm index capture with cfg_k=2 and verdicts 0,0,1,1.
      do_reset(4'd2);
      window(1'b0, 1'b0, 1'b0, vote, wc, al, irq);
      window(1'b0, 1'b0, 1'b0, vote, wc, al, irq);
      window(1'b1, 1'b0, 1'b0, vote, wc, al, irq);
      window(1'b0, 1'b1, 1'b0, vote, wc, al, irq);
      check("ts_alarm", 32'(al), 32'd1);
`ifdef ALARM_TIMESTAMP_EN
      check("ts_idx", 32'(bus.alarm_window_idx), 32'd4);
`endif

      // Random windows, acks and ack-on-close against the model.
      for (int seg = 0; seg < 3; seg++) begin
         do_reset(4'($urandom_range(0, 10)));
         for (int n = 0; n < 100; n++) begin
            if ($urandom_range(0, 3) == 0) do_ack();
            window(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 7) == 0), vote, wc, al, irq);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
